// File: rtl/param_universal_shift_register.sv
// Universal shift register with an automatic burst-shift engine.
//
// Purpose:
//   WIDTH-bit register supporting hold, serial shift left/right, parallel
//   load, rotate left/right and clear, selected by mode_i. A burst request
//   latches a shift count and direction, then performs one serial shift per
//   enabled cycle until the count is exhausted, pulsing done_o at the end.
//
// Ports:
//   clk_i          - clock, all state updates on rising edge
//   rst_i          - synchronous active-high reset
//   en_i           - clock enable; 0 freezes all state (reset still acts)
//   mode_i         - operation select when idle
//   ser_in_l_i     - serial bit entering out_o[0] on left shift
//   ser_in_r_i     - serial bit entering out_o[WIDTH-1] on right shift
//   par_in_i       - parallel load data
//   burst_start_i  - level-sampled burst request
//   burst_dir_i    - burst direction (0 = left, 1 = right), latched at start
//   burst_len_i    - burst shift count, latched at start
//   out_o          - register contents
//   ser_out_msb_o  - out_o[WIDTH-1]
//   ser_out_lsb_o  - out_o[0]
//   busy_o         - registered, high while a burst is in progress
//   done_o         - registered, one-cycle pulse at burst completion

module param_universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_in_l_i,
  input  logic             ser_in_r_i,
  input  logic [WIDTH-1:0] par_in_i,
  input  logic             burst_start_i,
  input  logic             burst_dir_i,
  input  logic [LEN_W-1:0] burst_len_i,
  output logic [WIDTH-1:0] out_o,
  output logic             ser_out_msb_o,
  output logic             ser_out_lsb_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] ModeHold  = 3'b000;
  localparam logic [2:0] ModeShl   = 3'b001;
  localparam logic [2:0] ModeShr   = 3'b010;
  localparam logic [2:0] ModeLoad  = 3'b011;
  localparam logic [2:0] ModeRotl  = 3'b100;
  localparam logic [2:0] ModeRotr  = 3'b101;
  localparam logic [2:0] ModeClear = 3'b110;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               last_shift;
  logic               len_zero;

  assign last_shift = (cnt_q == LEN_W'(1));
  assign len_zero   = (burst_len_i == '0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      out_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: burst sequencing and the remaining-shift counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (en_i) begin
      unique case (state_q)
        StIdle: begin
          if (burst_start_i && !len_zero) begin
            state_d = StBurst;
            cnt_d   = burst_len_i;
            dir_d   = burst_dir_i;
          end
        end
        StBurst: begin
          cnt_d = cnt_q - LEN_W'(1);
          if (last_shift) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic: next register contents and the registered status flags.
  always_comb begin
    out_d  = out_q;
    busy_d = busy_q;
    // done is a pulse: it drops on every edge it is not re-asserted.
    done_d = 1'b0;
    if (en_i) begin
      unique case (state_q)
        StIdle: begin
          if (burst_start_i) begin
            // Start edge never touches out; a zero-length burst completes at once.
            busy_d = !len_zero;
            done_d = len_zero;
          end else begin
            case (mode_i)
              ModeHold:  out_d = out_q;
              ModeShl:   out_d = {out_q[WIDTH-2:0], ser_in_l_i};
              ModeShr:   out_d = {ser_in_r_i, out_q[WIDTH-1:1]};
              ModeLoad:  out_d = par_in_i;
              ModeRotl:  out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
              ModeRotr:  out_d = {out_q[0], out_q[WIDTH-1:1]};
              ModeClear: out_d = '0;
              default:   out_d = out_q;
            endcase
          end
        end
        StBurst: begin
          if (dir_q) begin
            out_d = {ser_in_r_i, out_q[WIDTH-1:1]};
          end else begin
            out_d = {out_q[WIDTH-2:0], ser_in_l_i};
          end
          if (last_shift) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
        default: begin
          busy_d = 1'b0;
        end
      endcase
    end
  end

  assign out_o         = out_q;
  assign ser_out_msb_o = out_q[WIDTH-1];
  assign ser_out_lsb_o = out_q[0];
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed self-checking bench for param_universal_shift_register (WIDTH=8, LEN_W=4).
module tb_param_universal_shift_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       ser_in_l;
  logic       ser_in_r;
  logic [7:0] par_in;
  logic       burst_start;
  logic       burst_dir;
  logic [3:0] burst_len;
  logic [7:0] out;
  logic       ser_out_msb;
  logic       ser_out_lsb;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails  = 0;

  param_universal_shift_register #(
    .WIDTH(8),
    .LEN_W(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .mode_i       (mode),
    .ser_in_l_i   (ser_in_l),
    .ser_in_r_i   (ser_in_r),
    .par_in_i     (par_in),
    .burst_start_i(burst_start),
    .burst_dir_i  (burst_dir),
    .burst_len_i  (burst_len),
    .out_o        (out),
    .ser_out_msb_o(ser_out_msb),
    .ser_out_lsb_o(ser_out_lsb),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Per-cycle invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (ser_out_msb !== out[7] || ser_out_lsb !== out[0]) begin
        fails++;
        $display("FAIL ser_out: msb=%b lsb=%b out=%h", ser_out_msb, ser_out_lsb, out);
      end
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        fails++;
        $display("FAIL busy_and_done: busy=%b done=%b, required not both high", busy, done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 3'b011; par_in = 8'hFF;
    ser_in_l = 1'b0; ser_in_r = 1'b0;
    burst_start = 1'b0; burst_dir = 1'b0; burst_len = 4'd0;
    tick();
    tick();
    checks++;
    if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: out=%h busy=%b done=%b, required 00/0/0", out, busy, done);
    end
    rst = 1'b0; en = 1'b1; mode = 3'b000;
  endtask

  task automatic test_shift_left();
    logic [7:0] exp_l [4] = '{8'h01, 8'h03, 8'h07, 8'h0E};
    mode = 3'b001;
    for (int i = 0; i < 4; i++) begin
      ser_in_l = (i < 3);
      tick();
      checks++;
      if (out !== exp_l[i]) begin
        fails++;
        $display("FAIL shift_left[%0d]: out=%h required %h", i, out, exp_l[i]);
      end
    end
    mode = 3'b000;
  endtask

  task automatic test_modes();
    logic [2:0] m   [7] = '{3'b011, 3'b100, 3'b011, 3'b101, 3'b011, 3'b010, 3'b110};
    logic [7:0] exp_m [7] = '{8'hA5, 8'h4B, 8'hA5, 8'hD2, 8'hA5, 8'hD2, 8'h00};
    par_in = 8'hA5; ser_in_r = 1'b1; ser_in_l = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mode = m[i];
      tick();
      checks++;
      if (out !== exp_m[i]) begin
        fails++;
        $display("FAIL mode[%0d] mode=%b: out=%h required %h", i, m[i], out, exp_m[i]);
      end
    end
    // Hold modes and clock-enable freeze.
    par_in = 8'h3C; mode = 3'b011;
    tick();
    mode = 3'b111;
    tick();
    mode = 3'b000;
    tick();
    checks++;
    if (out !== 8'h3C) begin
      fails++;
      $display("FAIL hold: out=%h required 3c", out);
    end
    en = 1'b0; mode = 3'b110;
    tick();
    checks++;
    if (out !== 8'h3C) begin
      fails++;
      $display("FAIL en_freeze: out=%h required 3c", out);
    end
    en = 1'b1; mode = 3'b000; ser_in_r = 1'b0;
  endtask

  task automatic test_burst_right();
    logic [7:0] exp_o [3] = '{8'h40, 8'h20, 8'h10};
    logic       exp_b [3] = '{1'b1, 1'b1, 1'b0};
    logic       exp_d [3] = '{1'b0, 1'b0, 1'b1};
    par_in = 8'h81; mode = 3'b011;
    tick();
    // Mode must be ignored on the start edge and during the burst.
    par_in = 8'hFF;
    burst_start = 1'b1; burst_dir = 1'b1; burst_len = 4'd3; ser_in_r = 1'b0;
    tick();
    checks++;
    if (out !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL burst_start: out=%h busy=%b done=%b, required 81/1/0", out, busy, done);
    end
    burst_start = 1'b0; burst_len = 4'd9; burst_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== exp_o[i] || busy !== exp_b[i] || done !== exp_d[i]) begin
        fails++;
        $display("FAIL burst_right[%0d]: out=%h busy=%b done=%b, required %h/%b/%b",
                 i, out, busy, done, exp_o[i], exp_b[i], exp_d[i]);
      end
    end
    mode = 3'b000;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== 8'h10) begin
      fails++;
      $display("FAIL burst_after: out=%h busy=%b done=%b, required 10/0/0", out, busy, done);
    end
  endtask

  task automatic test_burst_len0_and_pause();
    burst_start = 1'b1; burst_len = 4'd0; mode = 3'b000;
    tick();
    checks++;
    if (out !== 8'h10 || busy !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL len0: out=%h busy=%b done=%b, required 10/0/1", out, busy, done);
    end
    burst_start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || out !== 8'h10) begin
      fails++;
      $display("FAIL len0_pulse: out=%h done=%b, required 10/0", out, done);
    end
    // len=2 left burst paused for two cycles.
    burst_start = 1'b1; burst_len = 4'd2; burst_dir = 1'b0; ser_in_l = 1'b1;
    tick();
    burst_start = 1'b0;
    tick();
    checks++;
    if (out !== 8'h21 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pause_shift1: out=%h busy=%b, required 21/1", out, busy);
    end
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (out !== 8'h21 || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL pause_hold: out=%h busy=%b done=%b, required 21/1/0", out, busy, done);
    end
    en = 1'b1;
    tick();
    checks++;
    if (out !== 8'h43 || busy !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL pause_done: out=%h busy=%b done=%b, required 43/0/1", out, busy, done);
    end
    tick();
    checks++;
    if (out !== 8'h43 || done !== 1'b0) begin
      fails++;
      $display("FAIL pause_end: out=%h done=%b, required 43/0", out, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    mode = 3'b011; par_in = 8'hFF; ser_in_l = 1'b0;
    burst_start = 1'b1; burst_len = 4'd5; burst_dir = 1'b0;
    tick();
    burst_start = 1'b0;
    tick();
    checks++;
    if (out !== 8'h86 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_burst_shift: out=%h busy=%b, required 86/1", out, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_burst: out=%h busy=%b done=%b, required 00/0/0", out, busy, done);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL post_rst[%0d]: out=%h busy=%b done=%b, required ff/0/0",
                 i, out, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_o [4] = '{8'hFF, 8'hFE, 8'hFE, 8'hFC};
    logic       exp_b [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_d [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    mode = 3'b000; ser_in_l = 1'b0;
    burst_start = 1'b1; burst_len = 4'd1; burst_dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out !== exp_o[i] || busy !== exp_b[i] || done !== exp_d[i]) begin
        fails++;
        $display("FAIL back_to_back[%0d]: out=%h busy=%b done=%b, required %h/%b/%b",
                 i, out, busy, done, exp_o[i], exp_b[i], exp_d[i]);
      end
    end
    burst_start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 8'hFC) begin
      fails++;
      $display("FAIL b2b_end: out=%h busy=%b done=%b, required fc/0/0", out, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_modes();
    test_burst_right();
    test_burst_len0_and_pause();
    test_reset_mid_burst();
    test_back_to_back();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
